// File: rtl/ibex_alu_pext_mac_seq.sv
// P-ext multiply-accumulate sequencer: rd = c +/- a*b per lane, one shared 17x17 multiplier, valid_o 3 (2x16b) or 5 (1x32b) cycles after start.
// One op in flight; start_i only taken while ready_o=1. Lane clamping and ov_o are built only with PEXT_MAC_SAT_EN defined.
module ibex_alu_pext_mac_seq #(
   parameter logic ResultHold = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start_i,
   input  logic        kill_i,
   input  logic        width32_i,
   input  logic        signed_i,
   input  logic        sub_i,
   input  logic [31:0] op_a_i,
   input  logic [31:0] op_b_i,
   input  logic [31:0] op_c_i,
   output logic        ready_o,
   output logic        valid_o,
   output logic [31:0] result_o,
   output logic        ov_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      ACC  = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [1:0]  cnt_q;
   logic [31:0] a_q, b_q, c_q;
   logic        w32_q, sgn_q, sub_q;
   logic [63:0] accum_q;
   logic [31:0] res_q;
   logic        ov_q;

   logic        launch, mul_step, last_cnt;
   logic [31:0] acc_res;
   logic        acc_ov;

   assign last_cnt = (cnt_q == (w32_q ? 2'd3 : 2'd1));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // kill_i wins over the ACC result, so valid_o is suppressed in the same cycle
   always_comb begin
      state_d  = state_q;
      ready_o  = 1'b0;
      valid_o  = 1'b0;
      launch   = 1'b0;
      mul_step = 1'b0;
      case (state_q)
         IDLE: begin
            ready_o = 1'b1;
            if (start_i) begin
               launch  = 1'b1;
               state_d = MUL;
            end
         end
         MUL: begin
            if (kill_i) begin
               state_d = IDLE;
            end else begin
               mul_step = 1'b1;
               if (last_cnt) begin
                  state_d = ACC;
               end
            end
         end
         ACC: begin
            state_d = IDLE;
            if (!kill_i) begin
               valid_o = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   logic               a_hi, b_hi;
   logic [15:0]        a_half, b_half;
   logic signed [16:0] mul_a, mul_b;
   logic signed [33:0] prod;
   logic [63:0]        prod_ext, pp;

   // 32-bit mode sequence aL*bL, aH*bL, aL*bH, aH*bH; only high halves carry the sign there
   always_comb begin
      a_hi   = cnt_q[0];
      b_hi   = w32_q ? cnt_q[1] : cnt_q[0];
      a_half = a_hi ? a_q[31:16] : a_q[15:0];
      b_half = b_hi ? b_q[31:16] : b_q[15:0];
      mul_a  = {sgn_q & (a_hi | ~w32_q) & a_half[15], a_half};
      mul_b  = {sgn_q & (b_hi | ~w32_q) & b_half[15], b_half};
   end

   assign prod     = mul_a * mul_b;
   assign prod_ext = {{30{prod[33]}}, prod};

   always_comb begin
      case (cnt_q)
         2'd0:    pp = prod_ext;
         2'd3:    pp = prod_ext << 32;
         default: pp = prod_ext << 16;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         w32_q   <= 1'b0;
         sgn_q   <= 1'b0;
         sub_q   <= 1'b0;
         cnt_q   <= '0;
         accum_q <= '0;
      end else if (launch) begin
         a_q     <= op_a_i;
         b_q     <= op_b_i;
         c_q     <= op_c_i;
         w32_q   <= width32_i;
         sgn_q   <= signed_i;
         sub_q   <= sub_i;
         cnt_q   <= 2'd0;
         accum_q <= '0;
      end else if (mul_step) begin
         cnt_q <= cnt_q + 2'd1;
         if (w32_q) begin
            accum_q <= accum_q + pp;
         end else if (cnt_q[0]) begin
            accum_q[63:32] <= prod[31:0];
         end else begin
            accum_q[31:0] <= prod[31:0];
         end
      end
   end

   function automatic logic [33:0] add_sub(input logic [33:0] x, input logic [33:0] y,
                                           input logic do_sub);
      return do_sub ? (x - y) : (x + y);
   endfunction

   logic [33:0] s_lo, s_hi, s_w;

   // all sums at 34 bits so neither the unsigned borrow nor the signed overflow is lost
   assign s_lo = add_sub({{18{sgn_q & c_q[15]}}, c_q[15:0]},
                         {{2{sgn_q & accum_q[31]}}, accum_q[31:0]}, sub_q);
   assign s_hi = add_sub({{18{sgn_q & c_q[31]}}, c_q[31:16]},
                         {{2{sgn_q & accum_q[63]}}, accum_q[63:32]}, sub_q);
   assign s_w  = add_sub({{2{sgn_q & c_q[31]}}, c_q},
                         {{2{sgn_q & accum_q[63]}}, accum_q[63:32]}, sub_q);

`ifdef PEXT_MAC_SAT_EN
   function automatic logic [16:0] sat16(input logic [33:0] s, input logic sgn);
      logic [16:0] r;
      r = {1'b0, s[15:0]};
      if (sgn) begin
         if (!s[33] && (|s[32:15])) begin
            r = {1'b1, 16'h7FFF};
         end else if (s[33] && !(&s[32:15])) begin
            r = {1'b1, 16'h8000};
         end
      end else begin
         if (s[33]) begin
            r = {1'b1, 16'h0000};
         end else if (|s[32:16]) begin
            r = {1'b1, 16'hFFFF};
         end
      end
      return r;
   endfunction

   function automatic logic [32:0] sat32(input logic [33:0] s, input logic sgn);
      logic [32:0] r;
      r = {1'b0, s[31:0]};
      if (sgn) begin
         if (!s[33] && (|s[32:31])) begin
            r = {1'b1, 32'h7FFF_FFFF};
         end else if (s[33] && !(&s[32:31])) begin
            r = {1'b1, 32'h8000_0000};
         end
      end else begin
         if (s[33]) begin
            r = {1'b1, 32'h0000_0000};
         end else if (s[32]) begin
            r = {1'b1, 32'hFFFF_FFFF};
         end
      end
      return r;
   endfunction

   logic [16:0] lane0, lane1;
   logic [32:0] word;

   assign lane0   = sat16(s_lo, sgn_q);
   assign lane1   = sat16(s_hi, sgn_q);
   assign word    = sat32(s_w, sgn_q);
   assign acc_res = w32_q ? word[31:0] : {lane1[15:0], lane0[15:0]};
   assign acc_ov  = w32_q ? word[32] : (lane0[16] | lane1[16]);
`else
   logic unused_sum_hi;

   assign acc_res       = w32_q ? s_w[31:0] : {s_hi[15:0], s_lo[15:0]};
   assign acc_ov        = 1'b0;
   assign unused_sum_hi = ^{s_lo[33:16], s_hi[33:16], s_w[33:32]};
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         res_q <= '0;
         ov_q  <= 1'b0;
      end else if (valid_o) begin
         res_q <= acc_res;
         ov_q  <= acc_ov;
      end
   end

   always_comb begin
      result_o = '0;
      ov_o     = 1'b0;
      if (valid_o) begin
         result_o = acc_res;
         ov_o     = acc_ov;
      end else if (ResultHold) begin
         result_o = res_q;
         ov_o     = ov_q;
      end
   end

endmodule

// File: tb/tb_ibex_alu_pext_mac_seq.sv
// Bench for ibex_alu_pext_mac_seq: directed vector table, kill/reset sequences, randomized ops vs an arithmetic model.
module tb_ibex_alu_pext_mac_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        kill = 1'b0;
   logic        w32 = 1'b0;
   logic        sgn = 1'b0;
   logic        sub = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic [31:0] c = '0;
   logic        ready, valid, ov;
   logic [31:0] result;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] last_res = '0;
   logic        last_ov = 1'b0;

   ibex_alu_pext_mac_seq dut (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .start_i   (start),
      .kill_i    (kill),
      .width32_i (w32),
      .signed_i  (sgn),
      .sub_i     (sub),
      .op_a_i    (a),
      .op_b_i    (b),
      .op_c_i    (c),
      .ready_o   (ready),
      .valid_o   (valid),
      .result_o  (result),
      .ov_o      (ov)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        w32;
      logic        sgn;
      logic        sub;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
      logic [31:0] res;
      logic        ov;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic longint ext(input logic [31:0] v, input int w, input logic s);
      longint r;
      if (w == 16) r = s ? longint'($signed(v[15:0])) : longint'(v[15:0]);
      else         r = s ? longint'($signed(v)) : longint'(v);
      return r;
   endfunction

   // Reference: exact integer products and sums, then clamp (or wrap) to the lane width
   task automatic model(input logic mw32, input logic ms, input logic msub,
                        input logic [31:0] ma, input logic [31:0] mb, input logic [31:0] mc,
                        output logic [31:0] r, output logic o);
      longint      p, s, lo, hi, hw;
      logic [63:0] pv;
      logic [31:0] la, lb, lc;
      o = 1'b0;
      r = '0;
      if (mw32) begin
         p  = ext(ma, 32, ms) * ext(mb, 32, ms);
         pv = p;
         hw = ext(pv[63:32], 32, ms);
         s  = msub ? ext(mc, 32, ms) - hw : ext(mc, 32, ms) + hw;
         lo = ms ? -64'sd2147483648 : 64'sd0;
         hi = ms ? 64'sd2147483647 : 64'sd4294967295;
`ifdef PEXT_MAC_SAT_EN
         if (s > hi) begin s = hi; o = 1'b1; end
         else if (s < lo) begin s = lo; o = 1'b1; end
`endif
         pv = s;
         r  = pv[31:0];
      end else begin
         for (int l = 0; l < 2; l++) begin
            la = {16'h0, ma[16*l +: 16]};
            lb = {16'h0, mb[16*l +: 16]};
            lc = {16'h0, mc[16*l +: 16]};
            p  = ext(la, 16, ms) * ext(lb, 16, ms);
            s  = msub ? ext(lc, 16, ms) - p : ext(lc, 16, ms) + p;
            lo = ms ? -64'sd32768 : 64'sd0;
            hi = ms ? 64'sd32767 : 64'sd65535;
`ifdef PEXT_MAC_SAT_EN
            if (s > hi) begin s = hi; o = 1'b1; end
            else if (s < lo) begin s = lo; o = 1'b1; end
`endif
            pv = s;
            r[16*l +: 16] = pv[15:0];
         end
      end
   endtask

   // Called at a negedge; returns at the negedge of the cycle after valid_o
   task automatic run_op(input logic tw32, input logic ts, input logic tsub,
                         input logic [31:0] ta, input logic [31:0] tb, input logic [31:0] tc,
                         input logic tkill, output logic [31:0] r, output logic o, output int lat);
      chk("ready_at_start", {31'b0, ready}, 32'd1);
      w32 = tw32; sgn = ts; sub = tsub; a = ta; b = tb; c = tc;
      start = 1'b1;
      kill  = tkill;
      @(negedge clk);
      start = 1'b0;
      kill  = 1'b0;
      lat   = 1;
      while (!valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk("valid_seen", {31'b0, valid}, 32'd1);
      r = result;
      o = ov;
      @(negedge clk);
      chk("valid_one_cycle", {31'b0, valid}, 32'd0);
      chk("ready_after_acc", {31'b0, ready}, 32'd1);
   endtask

   function automatic logic [15:0] edge16();
      logic [15:0] v;
      case ($urandom_range(0, 5))
         0: v = 16'h0000;
         1: v = 16'h0001;
         2: v = 16'h7FFF;
         3: v = 16'h8000;
         4: v = 16'hFFFF;
         default: v = 16'($urandom);
      endcase
      return v;
   endfunction

   function automatic logic [31:0] rnd_word();
      logic [31:0] v;
      if ($urandom_range(0, 1) == 0) v = $urandom;
      else v = {edge16(), edge16()};
      return v;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t        vecs[6];
      logic [31:0] r, er;
      logic        o, eo;
      int          lat, seen;
      logic        rw32, rs, rsub;
      logic [31:0] ra, rb, rc;

      vecs[0] = '{1'b0, 1'b1, 1'b0, 32'h0002_0003, 32'h0004_0005, 32'h0001_0001, 32'h0009_0010, 1'b0};
      vecs[2] = '{1'b1, 1'b1, 1'b1, 32'h4000_0000, 32'h0000_0004, 32'h0000_0005, 32'h0000_0004, 1'b0};
`ifdef PEXT_MAC_SAT_EN
      vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h7FFF_7FFF, 32'h7FFF_7FFF, 32'h7FFF_0000, 32'h7FFF_7FFF, 1'b1};
      vecs[3] = '{1'b0, 1'b0, 1'b1, 32'h0001_0003, 32'h0001_0002, 32'h0000_0005, 32'h0000_0000, 1'b1};
      vecs[4] = '{1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1};
      vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h7FFF_FFFF, 1'b1};
`else
      vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h7FFF_7FFF, 32'h7FFF_7FFF, 32'h7FFF_0000, 32'h8000_0001, 1'b0};
      vecs[3] = '{1'b0, 1'b0, 1'b1, 32'h0001_0003, 32'h0001_0002, 32'h0000_0005, 32'hFFFF_FFFF, 1'b0};
      vecs[4] = '{1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0005, 32'h0000_0003, 1'b0};
      vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 1'b0};
`endif

      repeat (3) @(negedge clk);
      chk("reset_ready", {31'b0, ready}, 32'd1);
      chk("reset_valid", {31'b0, valid}, 32'd0);
      chk("reset_result", result, 32'd0);
      chk("reset_ov", {31'b0, ov}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         run_op(vecs[i].w32, vecs[i].sgn, vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].c,
                1'b0, r, o, lat);
         chk($sformatf("vec%0d_result", i), r, vecs[i].res);
         chk($sformatf("vec%0d_ov", i), {31'b0, o}, {31'b0, vecs[i].ov});
         chk($sformatf("vec%0d_latency", i), 32'(lat), vecs[i].w32 ? 32'd5 : 32'd3);
         last_res = vecs[i].res;
         last_ov  = vecs[i].ov;
      end

      // kill together with start in IDLE: start must still be taken
      run_op(vecs[0].w32, vecs[0].sgn, vecs[0].sub, vecs[0].a, vecs[0].b, vecs[0].c,
             1'b1, r, o, lat);
      chk("kill_start_result", r, vecs[0].res);
      chk("kill_start_latency", 32'(lat), 32'd3);
      last_res = vecs[0].res;
      last_ov  = vecs[0].ov;

      // kill in the second MUL cycle of a 32-bit op
      w32 = 1'b1; sgn = 1'b1; sub = 1'b0; a = 32'h1234_5678; b = 32'h0FED_CBA9; c = 32'h1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      kill = 1'b1;
      #1;
      chk("kill_mul_no_valid", {31'b0, valid}, 32'd0);
      @(negedge clk);
      kill = 1'b0;
      chk("kill_mul_ready", {31'b0, ready}, 32'd1);
      chk("kill_mul_valid", {31'b0, valid}, 32'd0);
      chk("kill_mul_result_held", result, last_res);
      chk("kill_mul_ov_held", {31'b0, ov}, {31'b0, last_ov});
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (valid) seen++;
      end
      chk("kill_mul_no_late_valid", 32'(seen), 32'd0);
      run_op(vecs[2].w32, vecs[2].sgn, vecs[2].sub, vecs[2].a, vecs[2].b, vecs[2].c,
             1'b0, r, o, lat);
      chk("after_kill_result", r, vecs[2].res);
      chk("after_kill_latency", 32'(lat), 32'd5);
      last_res = vecs[2].res;
      last_ov  = vecs[2].ov;

      // kill in the ACC cycle suppresses valid_o
      w32 = 1'b0; sgn = 1'b1; sub = 1'b0; a = 32'h0003_0003; b = 32'h0003_0003; c = 32'h0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      kill = 1'b1;
      #1;
      chk("kill_acc_no_valid", {31'b0, valid}, 32'd0);
      @(negedge clk);
      kill = 1'b0;
      chk("kill_acc_ready", {31'b0, ready}, 32'd1);
      chk("kill_acc_result_held", result, last_res);

      // asynchronous reset in the middle of a 32-bit MUL
      w32 = 1'b1; sgn = 1'b0; sub = 1'b0; a = 32'hFFFF_0001; b = 32'h0001_FFFF; c = 32'h7;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_ready", {31'b0, ready}, 32'd1);
      chk("rst_mid_valid", {31'b0, valid}, 32'd0);
      chk("rst_mid_result", result, 32'd0);
      chk("rst_mid_ov", {31'b0, ov}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (valid) seen++;
      end
      chk("rst_no_spurious_valid", 32'(seen), 32'd0);

      for (int i = 0; i < 200; i++) begin
         rw32 = 1'($urandom);
         rs   = 1'($urandom);
         rsub = 1'($urandom);
         ra   = rnd_word();
         rb   = rnd_word();
         rc   = rnd_word();
         model(rw32, rs, rsub, ra, rb, rc, er, eo);
         run_op(rw32, rs, rsub, ra, rb, rc, 1'b0, r, o, lat);
         chk($sformatf("rand%0d_result", i), r, er);
         chk($sformatf("rand%0d_ov", i), {31'b0, o}, {31'b0, eo});
         chk($sformatf("rand%0d_latency", i), 32'(lat), rw32 ? 32'd5 : 32'd3);
         chk($sformatf("rand%0d_hold", i), result, er);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
